// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one 8N1 transmitter
// among NUM_CH byte requesters. Each grant is sent as a header byte
// (HEADER_BASE | channel) followed by the payload byte. The transmitter is
// driven through a start/busy handshake; a missing busy acknowledge within
// ACK_TIMEOUT cycles drops the frame and sets a sticky error flag.
module uart_tx_scheduler #(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] HEADER_BASE = 8'hA0,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [3:0]            grant_ch,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIMIT = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    HDR_WAIT = 3'd2,
    DAT      = 3'd3,
    DAT_WAIT = 3'd4
  } state_t;

  state_t state, state_next;

  logic [3:0]        last_grant;
  logic [7:0]        payload;
  logic [CW-1:0]     cnt;
  logic              seen_busy;

  logic [3:0]        winner;
  logic              found;
  logic [4:0]        idx;
  logic [NUM_CH-1:0] shifted;
  logic [7:0]        sel_payload;
  logic              grant;
  logic              timeout;
  logic              entering;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    winner  = last_grant;
    found   = 1'b0;
    idx     = 5'd0;
    shifted = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = {1'b0, last_grant} + 5'(i);
      if (idx >= 5'(NUM_CH)) begin
        idx = idx - 5'(NUM_CH);
      end else begin
        idx = idx;
      end
      shifted = req_valid >> idx;
      if (!found && shifted[0]) begin
        found  = 1'b1;
        winner = idx[3:0];
      end else begin
        found  = found;
      end
    end
    sel_payload = 8'(req_data >> {winner, 3'b000});
  end

  // Next-state logic and handshake outputs; req_ready is combinational so a
  // requester sees its accept in the same cycle the grant is decided.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    tx_start   = 1'b0;
    grant      = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && !tx_busy && found) begin
          grant      = 1'b1;
          req_ready  = NUM_CH'(1) << winner;
          state_next = HDR;
        end else begin
          state_next = IDLE;
        end
      end
      HDR: begin
        tx_start   = 1'b1;
        state_next = HDR_WAIT;
      end
      DAT: begin
        tx_start   = 1'b1;
        state_next = DAT_WAIT;
      end
      HDR_WAIT, DAT_WAIT: begin
        if (seen_busy) begin
          if (!tx_busy) begin
            state_next = (state == HDR_WAIT) ? DAT : IDLE;
          end else begin
            state_next = state;
          end
        end else if (!tx_busy && (cnt >= CNT_LIMIT)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = state;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    entering = (state_next != state) && ((state_next == HDR) || (state_next == DAT));
  end

  // State, latched frame data, ack-timeout tracking and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 4'(NUM_CH - 1);
      payload    <= 8'h00;
      tx_data    <= 8'h00;
      grant_ch   <= 4'h0;
      err        <= 1'b0;
      cnt        <= '0;
      seen_busy  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant <= winner;
        grant_ch   <= winner;
        payload    <= sel_payload;
        tx_data    <= HEADER_BASE | {4'b0000, winner};
      end else if ((state == HDR_WAIT) && (state_next == DAT)) begin
        tx_data    <= payload;
      end else begin
        tx_data    <= tx_data;
      end
      if (timeout) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
      // Counter measures cycles since tx_start; busy sampled during HDR/DAT
      // (the start cycle itself) is not an acknowledge.
      if (entering) begin
        cnt       <= '0;
        seen_busy <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end else begin
          cnt <= cnt;
        end
        if (((state == HDR_WAIT) || (state == DAT_WAIT)) && tx_busy) begin
          seen_busy <= 1'b1;
        end else begin
          seen_busy <= seen_busy;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler with a simple transmitter model
// (busy rises one cycle after tx_start and stays high for 20 cycles).
module tb_uart_tx_scheduler;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] req_valid = '0;
  logic [31:0]       req_data = '0;
  logic [NUM_CH-1:0] req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [3:0]        grant_ch;
  logic              busy;
  logic              err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic              busy_m = 1'b0;
  logic              force_busy = 1'b0;
  logic              model_en = 1'b1;
  logic              model_active = 1'b0;
  int                model_cnt = 0;
  logic [NUM_CH-1:0] hold_mask = '0;
  logic [NUM_CH-1:0] clr_mask = '0;
  logic              err_prev = 1'b0;
  int                err_cyc = -1;

  logic [3:0] grant_log[$];
  int         grant_cyc[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  logic [7:0] exp_tx[$];
  logic [3:0] exp_gr[$];

  assign tx_busy = busy_m | force_busy;

  uart_tx_scheduler #(.NUM_CH(NUM_CH), .HEADER_BASE(8'hA0), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_ch(grant_ch), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Requesters drop req_valid just after the edge on which they were accepted.
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~clr_mask;
    clr_mask = '0;
  end

  // Monitor and transmitter model, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ready[i]) begin
        grant_log.push_back(4'(i));
        grant_cyc.push_back(cyc);
        if (!hold_mask[i]) clr_mask[i] = 1'b1;
      end
    end
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
    if (tx_start && model_en) begin
      model_active = 1'b1;
      model_cnt = 0;
    end else if (model_active) begin
      model_cnt++;
      if (model_cnt == 1) busy_m = 1'b1;
      else if (model_cnt == 21) begin
        busy_m = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); tx_log.delete(); tx_cyc.delete();
  endtask

  task automatic wait_quiet(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #2;
      if (req_valid == '0 && !busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if (grant_ch !== 4'd0) begin bad++; $display("FAIL reset_grant_ch got=%0d want=0", grant_ch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok; int r;
    clear_logs();
    @(posedge clk); #2;
    req_data[23:16] = 8'h5A; req_valid = 4'b0100; r = cyc;
    wait_quiet(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy want=idle"); end
    total++; if (grant_log.size() != 1 || grant_log[0] !== 4'd2) begin bad++; $display("FAIL single_grant got n=%0d ch=%0d want n=1 ch=2", grant_log.size(), grant_log[0]); end
    total++; if (grant_cyc[0] != r) begin bad++; $display("FAIL single_ready_lat got=%0d want=%0d", grant_cyc[0], r); end
    exp_tx = '{8'hA2, 8'h5A};
    total++; if (tx_log.size() != 2) begin bad++; $display("FAIL single_tx_count got=%0d want=2", tx_log.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) begin bad++; $display("FAIL single_tx%0d got=%h want=%h", i, tx_log[i], exp_tx[i]); end
    end
    total++; if (tx_cyc[0] != r + 1) begin bad++; $display("FAIL single_hdr_lat got=%0d want=%0d", tx_cyc[0], r + 1); end
    total++; if (tx_cyc[1] != r + 23) begin bad++; $display("FAIL single_dat_lat got=%0d want=%0d", tx_cyc[1], r + 23); end
    total++; if (grant_ch !== 4'd2) begin bad++; $display("FAIL single_grant_ch got=%0d want=2", grant_ch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    clear_logs();
    @(posedge clk); #2;
    req_data = 32'h13121110; req_valid = 4'b1111;
    wait_quiet(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL contention_timeout got=busy want=idle"); end
    exp_tx = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13};
    total++; if (tx_log.size() != 8) begin bad++; $display("FAIL contention_count got=%0d want=8", tx_log.size()); end
    for (int i = 0; i < 8; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) begin bad++; $display("FAIL contention_tx%0d got=%h want=%h", i, tx_log[i], exp_tx[i]); end
    end
  endtask

  task automatic test_fairness();
    bit ok; int k;
    clear_logs();
    @(posedge clk); #2;
    req_data = 32'h23000020; hold_mask = 4'b1001; req_valid = 4'b1001;
    k = 0;
    while (grant_log.size() < 4 && k < 400) begin
      @(posedge clk); #2; k++;
    end
    req_valid = '0; hold_mask = '0;
    wait_quiet(200, ok);
    total++; if (!ok || k >= 400) begin bad++; $display("FAIL fairness_timeout got=k%0d want=<400", k); end
    exp_gr = '{4'd0, 4'd3, 4'd0, 4'd3};
    total++; if (grant_log.size() != 4) begin bad++; $display("FAIL fairness_count got=%0d want=4", grant_log.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (grant_log[i] !== exp_gr[i]) begin bad++; $display("FAIL fairness_grant%0d got=%0d want=%0d", i, grant_log[i], exp_gr[i]); end
    end
    exp_tx = '{8'hA0, 8'h20, 8'hA3, 8'h23, 8'hA0, 8'h20, 8'hA3, 8'h23};
    for (int i = 0; i < 8; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) begin bad++; $display("FAIL fairness_tx%0d got=%h want=%h", i, tx_log[i], exp_tx[i]); end
    end
  endtask

  task automatic test_busy_hold();
    bit ok; int f;
    clear_logs();
    @(posedge clk); #2;
    force_busy = 1'b1; req_data[15:8] = 8'h77; req_valid = 4'b0010;
    repeat (50) @(posedge clk);
    #2;
    total++; if (grant_log.size() != 0) begin bad++; $display("FAIL busyhold_no_grant got=%0d want=0", grant_log.size()); end
    total++; if (tx_log.size() != 0) begin bad++; $display("FAIL busyhold_no_start got=%0d want=0", tx_log.size()); end
    force_busy = 1'b0; f = cyc;
    wait_quiet(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL busyhold_timeout got=busy want=idle"); end
    total++; if (grant_log.size() != 1 || grant_cyc[0] != f) begin bad++; $display("FAIL busyhold_grant got n=%0d cyc=%0d want n=1 cyc=%0d", grant_log.size(), grant_cyc[0], f); end
    exp_tx = '{8'hA1, 8'h77};
    for (int i = 0; i < 2; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) begin bad++; $display("FAIL busyhold_tx%0d got=%h want=%h", i, tx_log[i], exp_tx[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok; int k;
    clear_logs();
    err_cyc = -1;
    @(posedge clk); #2;
    model_en = 1'b0; req_data[23:16] = 8'h99; req_valid = 4'b0100;
    k = 0;
    while (err !== 1'b1 && k < 100) begin
      @(posedge clk); #2; k++;
    end
    wait_quiet(100, ok);
    total++; if (!ok || k >= 100) begin bad++; $display("FAIL timeout_wait got=k%0d want=<100", k); end
    total++; if (err_cyc - tx_cyc[0] != 16) begin bad++; $display("FAIL timeout_latency got=%0d want=16", err_cyc - tx_cyc[0]); end
    total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hA2) begin bad++; $display("FAIL timeout_hdr_only got n=%0d b0=%h want n=1 b0=a2", tx_log.size(), tx_log[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
    clear_logs();
    model_en = 1'b1; req_data[7:0] = 8'h44; req_valid = 4'b0001;
    wait_quiet(200, ok);
    total++; if (!ok || tx_log.size() != 2 || tx_log[0] !== 8'hA0 || tx_log[1] !== 8'h44) begin bad++; $display("FAIL timeout_next_frame got n=%0d %h %h want n=2 a0 44", tx_log.size(), tx_log[0], tx_log[1]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", err); end
  endtask

  task automatic test_reset_mid();
    bit ok; int k;
    clear_logs();
    @(posedge clk); #2;
    req_data[15:8] = 8'h31; req_valid = 4'b0010;
    k = 0;
    while (tx_log.size() < 2 && k < 200) begin
      @(posedge clk); #2; k++;
    end
    repeat (3) @(posedge clk);
    #2;
    total++; if (k >= 200 || tx_busy !== 1'b1) begin bad++; $display("FAIL resetmid_setup got=k%0d busy=%b want=dat_wait", k, tx_busy); end
    reset = 1'b1; busy_m = 1'b0; model_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL resetmid_req_ready got=%b want=0000", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL resetmid_tx_start got=%b want=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL resetmid_tx_data got=%h want=00", tx_data); end
    total++; if (grant_ch !== 4'd0) begin bad++; $display("FAIL resetmid_grant_ch got=%0d want=0", grant_ch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL resetmid_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL resetmid_err got=%b want=0", err); end
    @(posedge clk); #2;
    reset = 1'b0;
    clear_logs();
    req_data = 32'h53000050; req_valid = 4'b1001;
    wait_quiet(300, ok);
    total++; if (!ok || grant_log.size() != 2 || grant_log[0] !== 4'd0 || grant_log[1] !== 4'd3) begin bad++; $display("FAIL resetmid_priority got n=%0d %0d %0d want n=2 0 3", grant_log.size(), grant_log[0], grant_log[1]); end
    exp_tx = '{8'hA0, 8'h50, 8'hA3, 8'h53};
    for (int i = 0; i < 4; i++) begin
      total++; if (tx_log[i] !== exp_tx[i]) begin bad++; $display("FAIL resetmid_tx%0d got=%h want=%h", i, tx_log[i], exp_tx[i]); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_busy_hold();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
